osd_stm_mc: RTL and testbench

Multi-channel system trace capture stage, successor to the single-channel STM capture path. Timestamps trace events from CHANNELS independent sources and holds each in a per-channel capture register. A round-robin arbiter moves the held events into a DEPTH-entry FIFO, which feeds the trace packetizer through a valid/ready stream. Lost events are counted, and the count is reported in-band as an overflow record.

---
 rtl/osd_stm_mc.sv | 170 +++++++++++++++++
 tb/tb_osd_stm_mc.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_stm_mc.sv
// osd_stm_mc: multi-channel trace capture with per-channel holding
// registers, a round-robin arbiter, an event FIFO and lost-event reporting.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stall              drop all incoming events (not counted as lost)
//   chan_enable        per-channel enable
//   trace_valid/id/value  per-channel event inputs (no backpressure)
//   out_data/out_overflow/out_valid/out_ready  record stream
//   lost_total         current unreported lost-event count
module osd_stm_mc #(
  parameter int CHANNELS    = 4,
  parameter int VALUE_WIDTH = 64,
  parameter int TS_WIDTH    = 32,
  parameter int DEPTH       = 8,
  parameter int LOST_WIDTH  = 16,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int EW = CW + 16 + VALUE_WIDTH + TS_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic [CHANNELS-1:0]             chan_enable,
  input  logic [CHANNELS-1:0]             trace_valid,
  input  logic [16*CHANNELS-1:0]          trace_id,
  input  logic [VALUE_WIDTH*CHANNELS-1:0] trace_value,
  output logic [EW-1:0]                   out_data,
  output logic                            out_overflow,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LOST_WIDTH-1:0]           lost_total
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = LOST_WIDTH + 5;

  logic [TS_WIDTH-1:0]    ts_q;
  logic [CHANNELS-1:0]    cap_full_q;
  logic [15:0]            cap_id_q  [CHANNELS];
  logic [VALUE_WIDTH-1:0] cap_val_q [CHANNELS];
  logic [TS_WIDTH-1:0]    cap_ts_q  [CHANNELS];
  logic [LOST_WIDTH-1:0]  lost_q, lost_d;
  logic [CW-1:0]          rr_q, rr_d;
  logic [AW:0]            wptr_q, rptr_q;
  logic [EW:0]            mem_q [DEPTH];

  logic                   empty, full, pop, space;
  logic                   ovf_push, norm_push, push;
  logic                   grant_vld;
  logic [CW-1:0]          grant;
  logic [CHANNELS-1:0]    accept, drain, load, loss;
  logic [4:0]             n_lost;
  logic [SW-1:0]          lost_sum;
  logic [EW:0]            push_rec;
  logic [EW:0]            head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop   = !empty && out_ready;
  // A pop frees the head slot, so a full FIFO can still take a push.
  assign space = !full || pop;

  // First full capture register at or after the round-robin pointer.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(rr_q) + i) % CHANNELS;
      if (!grant_vld && cap_full_q[idx]) begin
        grant_vld = 1'b1;
        grant     = CW'(idx);
      end
    end
  end

  assign ovf_push  = (lost_q != '0) && space;
  assign norm_push = !ovf_push && space && grant_vld;
  assign push      = ovf_push || norm_push;

  always_comb begin
    accept = trace_valid & chan_enable & {CHANNELS{!stall}};
    drain  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      drain[c] = norm_push && (grant == CW'(c));
    end
    load   = accept & (~cap_full_q | drain);
    loss   = accept & cap_full_q & ~drain;
    n_lost = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      n_lost = n_lost + 5'(loss[c]);
    end
  end

  // An overflow push reports the whole count, so only this
  // cycle's losses remain afterwards.
  always_comb begin
    lost_sum = SW'(n_lost);
    if (!ovf_push) begin
      lost_sum = lost_sum + SW'(lost_q);
    end
    if (lost_sum > SW'({LOST_WIDTH{1'b1}})) begin
      lost_d = {LOST_WIDTH{1'b1}};
    end else begin
      lost_d = lost_sum[LOST_WIDTH-1:0];
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (norm_push) begin
      rr_d = (grant == CW'(CHANNELS - 1)) ? '0 : grant + 1'b1;
    end
  end

  always_comb begin
    push_rec = '0;
    if (ovf_push) begin
      push_rec = {1'b1, EW'(lost_q)};
    end else begin
      push_rec = {1'b0, grant, cap_id_q[grant],
                  cap_val_q[grant], cap_ts_q[grant]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q       <= '0;
      cap_full_q <= '0;
      lost_q     <= '0;
      rr_q       <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        cap_id_q[c]  <= '0;
        cap_val_q[c] <= '0;
        cap_ts_q[c]  <= '0;
      end
    end else begin
      ts_q       <= ts_q + 1'b1;
      cap_full_q <= load | (cap_full_q & ~drain);
      lost_q     <= lost_d;
      rr_q       <= rr_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        if (load[c]) begin
          cap_id_q[c]  <= trace_id[16*c +: 16];
          cap_val_q[c] <= trace_value[VALUE_WIDTH*c +: VALUE_WIDTH];
          cap_ts_q[c]  <= ts_q;
        end
      end
    end
  end

  // Storage needs no reset: it is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= push_rec;
    end
  end

  assign head         = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign out_valid    = !empty;
  assign out_overflow = head[EW];
  assign out_data     = head[EW-1:0];
  assign lost_total   = lost_q;

endmodule

// File: tb/tb_osd_stm_mc.sv
// tb_osd_stm_mc: directed and random stimulus for osd_stm_mc,
// compared every cycle against a queue-based reference model.
module tb_osd_stm_mc;

  localparam int CH = 4;
  localparam int VW = 64;
  localparam int TW = 4;
  localparam int D  = 8;
  localparam int LW = 4;
  localparam int CW = 2;
  localparam int EW = CW + 16 + VW + TW;
  localparam int LMAX = (1 << LW) - 1;

  logic              clk;
  logic              rst;
  logic              stall;
  logic [CH-1:0]     chan_enable;
  logic [CH-1:0]     trace_valid;
  logic [16*CH-1:0]  trace_id;
  logic [VW*CH-1:0]  trace_value;
  logic [EW-1:0]     out_data;
  logic              out_overflow;
  logic              out_valid;
  logic              out_ready;
  logic [LW-1:0]     lost_total;

  osd_stm_mc #(
    .CHANNELS(CH), .VALUE_WIDTH(VW), .TS_WIDTH(TW),
    .DEPTH(D), .LOST_WIDTH(LW)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .chan_enable(chan_enable), .trace_valid(trace_valid),
    .trace_id(trace_id), .trace_value(trace_value),
    .out_data(out_data), .out_overflow(out_overflow),
    .out_valid(out_valid), .out_ready(out_ready),
    .lost_total(lost_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          m_ts;
  bit          m_cv [CH];
  logic [EW-1:0] m_cr [CH];
  int          m_lost;
  int          m_rr;
  logic [EW:0] m_q [$];

  function automatic int sat(int x);
    return (x > LMAX) ? LMAX : x;
  endfunction

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ts = 0;
    m_lost = 0;
    m_rr = 0;
    m_q.delete();
    for (int c = 0; c < CH; c++) begin
      m_cv[c] = 1'b0;
      m_cr[c] = '0;
    end
  endtask

  task automatic compare_all();
    logic [EW:0] h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    chk("out_valid", 128'(out_valid), 128'(m_q.size() > 0));
    chk("out_overflow", 128'(out_overflow), 128'(h[EW]));
    chk("out_data", 128'(out_data), 128'(h[EW-1:0]));
    chk("lost_total", 128'(lost_total), 128'(m_lost));
  endtask

  task automatic model_step();
    bit pop, space, ovf;
    int g, nl;
    logic [EW:0] grec;
    logic [EW-1:0] lrec;
    if (rst) begin
      model_reset();
      return;
    end
    pop   = (m_q.size() > 0) && out_ready;
    space = (m_q.size() < D) || pop;
    ovf   = (m_lost != 0) && space;
    g     = -1;
    grec  = '0;
    if (space && !ovf) begin
      for (int i = 0; i < CH; i++) begin
        int c;
        c = (m_rr + i) % CH;
        if (g < 0 && m_cv[c]) g = c;
      end
    end
    if (g >= 0) grec = {1'b0, m_cr[g]};
    if (pop) void'(m_q.pop_front());
    if (ovf) begin
      lrec = EW'(m_lost);
      m_q.push_back({1'b1, lrec});
    end
    if (g >= 0) begin
      m_q.push_back(grec);
      m_cv[g] = 1'b0;
      m_rr = (g + 1) % CH;
    end
    nl = 0;
    for (int c = 0; c < CH; c++) begin
      if (trace_valid[c] && chan_enable[c] && !stall) begin
        if (!m_cv[c]) begin
          m_cv[c] = 1'b1;
          m_cr[c] = {CW'(c), trace_id[16*c +: 16],
                     trace_value[VW*c +: VW], TW'(m_ts)};
        end else begin
          nl++;
        end
      end
    end
    m_lost = ovf ? sat(nl) : sat(m_lost + nl);
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic step();
    compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic ev(int c, logic [15:0] id, logic [VW-1:0] v);
    trace_valid[c] = 1'b1;
    trace_id[16*c +: 16] = id;
    trace_value[VW*c +: VW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [EW-1:0] exp1;

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    chan_enable = '1;
    trace_valid = '0;
    trace_id = '0;
    trace_value = '0;
    out_ready = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_ovf", 128'(out_overflow), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_lost", 128'(lost_total), 128'(0));

    // single event on ch2 at ts=5, visible two cycles later
    repeat (5) step();
    ev(2, 16'h1234, 64'hDEADBEEF);
    step();
    trace_valid = '0;
    chk("lat_t1_valid", 128'(out_valid), 128'(0));
    step();
    exp1 = {2'd2, 16'h1234, 64'hDEADBEEF, 4'd5};
    chk("lat_valid", 128'(out_valid), 128'(1));
    chk("lat_data", 128'(out_data), 128'(exp1));
    chk("lat_ovf", 128'(out_overflow), 128'(0));
    repeat (3) step();

    // all channels at once, then repeated ch0 events
    for (int c = 0; c < CH; c++) ev(c, 16'(16'h100 + c), 64'(c * 7));
    step();
    trace_valid = '0;
    ev(0, 16'hA000, 64'h1);
    step();
    ev(0, 16'hA001, 64'h2);
    step();
    trace_valid = '0;
    repeat (10) step();

    // fill FIFO with consumer stalled
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ev(0, 16'(i), 64'($urandom));
      step();
    end
    trace_valid = '0;
    chk("fill_lost", 128'(lost_total), 128'(11));
    chk("fill_valid", 128'(out_valid), 128'(1));
    out_ready = 1'b1;
    repeat (8) step();
    chk("fill_ovf_flag", 128'(out_overflow), 128'(1));
    chk("fill_ovf_data", 128'(out_data), 128'(11));
    repeat (4) step();

    // stall and disabled channel drop events silently
    stall = 1'b1;
    repeat (3) begin
      ev(1, 16'h5555, 64'h5);
      step();
    end
    stall = 1'b0;
    chan_enable = 4'b1101;
    repeat (3) begin
      ev(1, 16'h6666, 64'h6);
      step();
    end
    trace_valid = '0;
    chan_enable = '1;
    chk("drop_valid", 128'(out_valid), 128'(0));
    chk("drop_lost", 128'(lost_total), 128'(0));

    // lost counter saturation
    out_ready = 1'b0;
    repeat (20) begin
      for (int c = 0; c < CH; c++) ev(c, 16'($urandom), 64'($urandom));
      step();
    end
    trace_valid = '0;
    chk("sat_lost", 128'(lost_total), 128'(LMAX));

    // reset discards queued records and lost count
    do_reset();
    chk("mrst_valid", 128'(out_valid), 128'(0));
    chk("mrst_lost", 128'(lost_total), 128'(0));
    out_ready = 1'b1;
    ev(1, 16'hBEEF, 64'h77);
    step();
    trace_valid = '0;
    repeat (3) step();

    // timestamp wrap: event 17 cycles after reset carries ts=1
    do_reset();
    repeat (17) step();
    ev(3, 16'hC0DE, 64'h99);
    step();
    trace_valid = '0;
    step();
    chk("wrap_ts", 128'(out_data[TW-1:0]), 128'(1));
    repeat (3) step();

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 2) == 0) ev(c, 16'($urandom), {$urandom, $urandom});
        else trace_valid[c] = 1'b0;
      end
      chan_enable = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '1;
      stall = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    trace_valid = '0;
    stall = 1'b0;
    chan_enable = '1;
    out_ready = 1'b1;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
